candidate_selector: RTL

CANDIDATE_SELECTOR -- requirements
Module: candidate_selector

---
 rtl/candidate_selector_if.sv | 27 ++
 rtl/candidate_selector.sv | 105 ++++++++++
 2 files changed

// File: rtl/candidate_selector_if.sv
// Handshake and memory-bank bus of the candidate selector.
// The master side is the requester and memory model; the slave side is the selector.
interface candidate_selector_if #(
   parameter int IDX_W = 16
);
   logic             start;
   logic [4:0]       cand_count;
   logic [7:0]       q_min;
   logic [IDX_W-1:0] mem_index;
   logic [15:0]      mem_data;
   logic             busy;
   logic             done;
   logic             found;
   logic [7:0]       best_id;
   logic [7:0]       best_q;
   logic [3:0]       best_slot;

   modport master (
      output start, cand_count, q_min, mem_data,
      input  mem_index, busy, done, found, best_id, best_q, best_slot
   );

   modport slave (
      input  start, cand_count, q_min, mem_data,
      output mem_index, busy, done, found, best_id, best_q, best_slot
   );
endinterface

// File: rtl/candidate_selector.sv
// Scans up to SLOTS {id, q} words from a read-only bank, one per cycle, and
// keeps the highest Q-value at or above q_min (ties keep the lowest slot).
module candidate_selector #(
   parameter int SLOTS = 16,
   parameter int IDX_W = 16
) (
   input logic                 clk,
   input logic                 nrst,
   candidate_selector_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [4:0] MAX_COUNT = 5'(SLOTS);

   state_t     state;
   logic [4:0] slot;     // five bits so a count of 16 ends without wrapping
   logic [4:0] cnt_q;
   logic [7:0] q_min_q;
   logic       busy_q;
   logic       done_q;
   logic       found_q;
   logic [7:0] best_id_q;
   logic [7:0] best_q_q;
   logic [3:0] best_slot_q;

   logic [4:0] cnt_sat;
   logic [7:0] cur_q;
   logic       replace;

   assign cnt_sat = (bus.cand_count > MAX_COUNT) ? MAX_COUNT : bus.cand_count;
   assign cur_q   = bus.mem_data[7:0];
   assign replace = (cur_q >= q_min_q) && (!found_q || (cur_q > best_q_q));

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch,
      // and every state register uses non-blocking assignment to avoid read/write races.
      if (!nrst) begin
         state       <= IDLE;
         slot        <= '0;
         cnt_q       <= '0;
         q_min_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
         best_id_q   <= '0;
         best_q_q    <= '0;
         best_slot_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  cnt_q       <= cnt_sat;
                  q_min_q     <= bus.q_min;
                  slot        <= '0;
                  busy_q      <= 1'b1;
                  found_q     <= 1'b0;
                  best_id_q   <= '0;
                  best_q_q    <= '0;
                  best_slot_q <= '0;
                  if (cnt_sat == 5'd0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (replace) begin
                  found_q     <= 1'b1;
                  best_id_q   <= bus.mem_data[15:8];
                  best_q_q    <= cur_q;
                  best_slot_q <= slot[3:0];
               end
               if (slot == cnt_q - 5'd1) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  slot <= slot + 5'd1;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // Byte index of 16-bit words; zero outside SCAN so the bank sees a quiet bus.
   assign bus.mem_index = (state == SCAN) ? IDX_W'({slot, 1'b0}) : '0;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.found     = found_q;
   assign bus.best_id   = best_id_q;
   assign bus.best_q    = best_q_q;
   assign bus.best_slot = best_slot_q;
endmodule
